// File: rtl/decode_window.sv
// Decode window: registered window of up to WINDOW_BYTES bytes read from the fetch stage's circular buffer.
// Optional statistics counter enabled by macro DECODE_WINDOW_STATS_EN.
module decode_window #(
  parameter int BUF_BYTES    = 128,
  parameter int WINDOW_BYTES = 16,
  localparam int OW          = $clog2(BUF_BYTES),
  localparam int AW          = $clog2(WINDOW_BYTES) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [OW-1:0]             fetch_offset_in,
  input  logic [0:BUF_BYTES*8-1]    decode_buffer_in,
  input  logic                      flush_in,
  output logic [OW-1:0]             decode_offset_in,
  output logic                      win_valid,
  output logic [WINDOW_BYTES*8-1:0] win_bytes,
  output logic [AW-1:0]             win_avail,
  input  logic                      consume_valid,
  input  logic [AW-1:0]             consume_len,
  output logic                      err_consume,
  output logic [31:0]               stall_cycles
);

  logic [OW-1:0]             r_decode_offset;
  logic                      r_win_valid;
  logic [WINDOW_BYTES*8-1:0] r_win_bytes;
  logic [AW-1:0]             r_win_avail;
  logic                      r_err_consume;

  logic                      w_legal;
  logic                      w_illegal;
  logic [OW-1:0]             w_next_off;
  logic [OW-1:0]             w_next_avail;
  logic [AW-1:0]             w_win_avail;
  logic [WINDOW_BYTES*8-1:0] w_win_bytes;
  logic [OW-1:0]             w_idx;

  // Consume acceptance, next read pointer and next window contents
  always_comb begin
    w_legal      = 1'b0;
    w_illegal    = 1'b0;
    w_next_off   = r_decode_offset;
    w_next_avail = {OW{1'b0}};
    w_win_avail  = {AW{1'b0}};
    w_win_bytes  = {(WINDOW_BYTES*8){1'b0}};
    w_idx        = {OW{1'b0}};

    w_legal   = consume_valid && r_win_valid && (consume_len != {AW{1'b0}})
                && (consume_len <= r_win_avail);
    w_illegal = consume_valid && !w_legal;

    if (w_legal) begin
      w_next_off = r_decode_offset + {{(OW-AW){1'b0}}, consume_len};
    end else begin
      w_next_off = r_decode_offset;
    end

    // Modulo arithmetic at OW bits gives the circular distance directly
    w_next_avail = fetch_offset_in - w_next_off;
    if (w_next_avail >= OW'(WINDOW_BYTES)) begin
      w_win_avail = AW'(WINDOW_BYTES);
    end else begin
      w_win_avail = w_next_avail[AW-1:0];
    end

    for (int k = 0; k < WINDOW_BYTES; k++) begin
      w_idx = w_next_off + OW'(k);
      if (AW'(k) < w_win_avail) begin
        w_win_bytes[k*8 +: 8] = decode_buffer_in[{w_idx, 3'b000} +: 8];
      end else begin
        w_win_bytes[k*8 +: 8] = 8'h00;
      end
    end
  end

  // Read pointer, window register and sticky consume error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_decode_offset <= {OW{1'b0}};
      r_win_valid     <= 1'b0;
      r_win_bytes     <= {(WINDOW_BYTES*8){1'b0}};
      r_win_avail     <= {AW{1'b0}};
      r_err_consume   <= 1'b0;
    end else if (flush_in) begin
      r_decode_offset <= {OW{1'b0}};
      r_win_valid     <= 1'b0;
      r_win_bytes     <= {(WINDOW_BYTES*8){1'b0}};
      r_win_avail     <= {AW{1'b0}};
    end else begin
      r_decode_offset <= w_next_off;
      r_win_valid     <= (w_win_avail != {AW{1'b0}});
      r_win_bytes     <= w_win_bytes;
      r_win_avail     <= w_win_avail;
      if (w_illegal) begin
        r_err_consume <= 1'b1;
      end
    end
  end

`ifdef DECODE_WINDOW_STATS_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of cycles the decoder idles on a partial window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= 32'd0;
    end else if (!consume_valid && !flush_in && (r_win_avail < AW'(WINDOW_BYTES))
                 && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'd0;
`endif

  assign decode_offset_in = r_decode_offset;
  assign win_valid        = r_win_valid;
  assign win_bytes        = r_win_bytes;
  assign win_avail        = r_win_avail;
  assign err_consume      = r_err_consume;

endmodule

// File: tb/tb_decode_window.sv
// Directed self-checking bench for decode_window; buffer byte i holds 0x10 + i.
module tb_decode_window;

  logic           clk;
  logic           reset;
  logic [6:0]     fetch_offset_in;
  logic [0:1023]  decode_buffer_in;
  logic           flush_in;
  logic [6:0]     decode_offset_in;
  logic           win_valid;
  logic [127:0]   win_bytes;
  logic [4:0]     win_avail;
  logic           consume_valid;
  logic [4:0]     consume_len;
  logic           err_consume;
  logic [31:0]    stall_cycles;

  int checks = 0;
  int errors = 0;

  decode_window dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_offset_in  (fetch_offset_in),
    .decode_buffer_in (decode_buffer_in),
    .flush_in         (flush_in),
    .decode_offset_in (decode_offset_in),
    .win_valid        (win_valid),
    .win_bytes        (win_bytes),
    .win_avail        (win_avail),
    .consume_valid    (consume_valid),
    .consume_len      (consume_len),
    .err_consume      (err_consume),
    .stall_cycles     (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected window: n bytes starting at buffer offset off, rest zero
  function automatic logic [127:0] exp_win(input int off, input int n);
    logic [127:0] r;
    r = 128'd0;
    for (int k = 0; k < 16; k++) begin
      if (k < n) r[k*8 +: 8] = 8'(16 + ((off + k) % 128));
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic consume(input logic v, input int len);
    consume_valid = v;
    consume_len   = 5'(len);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    checks++;
    if (decode_offset_in !== 7'd0 || win_valid !== 1'b0 || win_avail !== 5'd0 ||
        win_bytes !== 128'd0 || err_consume !== 1'b0 || stall_cycles !== 32'd0) begin
      $display("FAIL reset: off=%0d valid=%0b avail=%0d err=%0b stall=%0d required all zero",
               decode_offset_in, win_valid, win_avail, err_consume, stall_cycles);
      errors++;
    end
    reset = 1'b1;
  endtask

  task automatic test_fill();
    fetch_offset_in = 7'd8;
    step();
    checks++;
    if (win_valid !== 1'b1 || win_avail !== 5'd8) begin
      $display("FAIL fill_avail: valid=%0b avail=%0d required 1/8", win_valid, win_avail);
      errors++;
    end
    checks++;
    if (win_bytes !== exp_win(0, 8)) begin
      $display("FAIL fill_bytes: got %h required %h", win_bytes, exp_win(0, 8));
      errors++;
    end
    checks++;
    if (decode_offset_in !== 7'd0) begin
      $display("FAIL fill_off: got %0d required 0", decode_offset_in);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    fetch_offset_in = 7'd24;
    step();
    checks++;
    if (win_avail !== 5'd16) begin
      $display("FAIL grow_avail: got %0d required 16", win_avail);
      errors++;
    end
    consume(1'b1, 3);
    step();
    checks++;
    if (decode_offset_in !== 7'd3 || win_avail !== 5'd16 || win_bytes[7:0] !== 8'h13) begin
      $display("FAIL consume3: off=%0d avail=%0d byte0=%h required 3/16/13",
               decode_offset_in, win_avail, win_bytes[7:0]);
      errors++;
    end
    consume(1'b1, 5);
    step();
    checks++;
    if (decode_offset_in !== 7'd8 || win_bytes !== exp_win(8, 16)) begin
      $display("FAIL b2b_first: off=%0d required 8", decode_offset_in);
      errors++;
    end
    step();
    consume(1'b0, 0);
    checks++;
    if (decode_offset_in !== 7'd13 || win_avail !== 5'd11 || win_bytes !== exp_win(13, 11)) begin
      $display("FAIL b2b_second: off=%0d avail=%0d required 13/11", decode_offset_in, win_avail);
      errors++;
    end
  endtask

  task automatic test_wrap();
    fetch_offset_in = 7'd127;
    step();
    for (int i = 0; i < 6; i++) begin
      consume(1'b1, 16);
      step();
    end
    consume(1'b1, 11);
    step();
    consume(1'b0, 0);
    fetch_offset_in = 7'd8;
    step();
    checks++;
    if (decode_offset_in !== 7'd120 || win_avail !== 5'd16) begin
      $display("FAIL wrap_pos: off=%0d avail=%0d required 120/16", decode_offset_in, win_avail);
      errors++;
    end
    checks++;
    if (win_bytes !== exp_win(120, 16)) begin
      $display("FAIL wrap_bytes: got %h required %h", win_bytes, exp_win(120, 16));
      errors++;
    end
    consume(1'b1, 10);
    step();
    consume(1'b0, 0);
    checks++;
    if (decode_offset_in !== 7'd2 || win_avail !== 5'd6 || win_bytes !== exp_win(2, 6)) begin
      $display("FAIL wrap_consume: off=%0d avail=%0d required 2/6", decode_offset_in, win_avail);
      errors++;
    end
  endtask

  task automatic test_illegal();
    fetch_offset_in = 7'd6;
    step();
    checks++;
    if (win_avail !== 5'd4 || err_consume !== 1'b0) begin
      $display("FAIL ill_setup: avail=%0d err=%0b required 4/0", win_avail, err_consume);
      errors++;
    end
    consume(1'b1, 6);
    step();
    checks++;
    if (decode_offset_in !== 7'd2 || err_consume !== 1'b1) begin
      $display("FAIL ill_toolong: off=%0d err=%0b required 2/1", decode_offset_in, err_consume);
      errors++;
    end
    consume(1'b0, 0);
    step();
    checks++;
    if (err_consume !== 1'b1) begin
      $display("FAIL ill_sticky: err=%0b required 1", err_consume);
      errors++;
    end
    consume(1'b1, 0);
    step();
    checks++;
    if (decode_offset_in !== 7'd2) begin
      $display("FAIL ill_zero: off=%0d required 2", decode_offset_in);
      errors++;
    end
    consume(1'b1, 4);
    step();
    checks++;
    if (decode_offset_in !== 7'd6 || win_valid !== 1'b0 || win_avail !== 5'd0) begin
      $display("FAIL exact_fit: off=%0d valid=%0b avail=%0d required 6/0/0",
               decode_offset_in, win_valid, win_avail);
      errors++;
    end
    consume(1'b1, 1);
    step();
    consume(1'b0, 0);
    checks++;
    if (decode_offset_in !== 7'd6) begin
      $display("FAIL ill_empty: off=%0d required 6", decode_offset_in);
      errors++;
    end
  endtask

  task automatic test_flush();
    fetch_offset_in = 7'd56;
    step();
    consume(1'b1, 16);
    step();
    step();
    consume(1'b1, 2);
    step();
    checks++;
    if (decode_offset_in !== 7'd40) begin
      $display("FAIL flush_setup: off=%0d required 40", decode_offset_in);
      errors++;
    end
    flush_in        = 1'b1;
    fetch_offset_in = 7'd0;
    consume(1'b1, 4);
    step();
    checks++;
    if (decode_offset_in !== 7'd0 || win_valid !== 1'b0 || win_avail !== 5'd0 ||
        win_bytes !== 128'd0 || err_consume !== 1'b1) begin
      $display("FAIL flush: off=%0d valid=%0b avail=%0d err=%0b required 0/0/0/1",
               decode_offset_in, win_valid, win_avail, err_consume);
      errors++;
    end
    flush_in        = 1'b0;
    fetch_offset_in = 7'd8;
    consume(1'b0, 0);
    step();
    checks++;
    if (win_avail !== 5'd8 || win_bytes !== exp_win(0, 8)) begin
      $display("FAIL post_flush: avail=%0d bytes=%h required 8/%h",
               win_avail, win_bytes, exp_win(0, 8));
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (decode_offset_in !== 7'd0 || win_valid !== 1'b0 || win_avail !== 5'd0 ||
        win_bytes !== 128'd0 || err_consume !== 1'b0) begin
      $display("FAIL reset_mid: valid=%0b avail=%0d err=%0b required 0/0/0",
               win_valid, win_avail, err_consume);
      errors++;
    end
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    checks++;
    if (win_valid !== 1'b0 || win_avail !== 5'd0) begin
      $display("FAIL reset_hold: valid=%0b avail=%0d required 0/0", win_valid, win_avail);
      errors++;
    end
  endtask

  task automatic test_stats();
    reset           = 1'b0;
    fetch_offset_in = 7'd4;
    consume(1'b0, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (win_avail !== 5'd4) begin
      $display("FAIL stats_avail: got %0d required 4", win_avail);
      errors++;
    end
    checks++;
`ifdef DECODE_WINDOW_STATS_EN
    if (stall_cycles !== 32'd10) begin
      $display("FAIL stall_count: got %0d required 10", stall_cycles);
      errors++;
    end
`else
    if (stall_cycles !== 32'd0) begin
      $display("FAIL stall_tied: got %0d required 0", stall_cycles);
      errors++;
    end
`endif
  endtask

  initial begin
    reset           = 1'b0;
    flush_in        = 1'b0;
    fetch_offset_in = 7'd0;
    consume_valid   = 1'b0;
    consume_len     = 5'd0;
    for (int i = 0; i < 128; i++) decode_buffer_in[i*8 +: 8] = 8'(16 + i);
    test_reset();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_window.md
Name: decode_window

Overview:
- Consumer stage directly downstream of instruction fetch.
- Reads the fetch stage's 128-byte circular decode buffer and maintains the read pointer (decode offset) that fetch uses for flow control.
- Presents a registered window of up to 16 instruction bytes, plus a valid-byte count, to the instruction decoder.
- Advances by the instruction length the decoder reports consumed.

Parameters:
- BUF_BYTES, 128, size of the circular decode buffer in bytes; power of two; offset width OW = log2(BUF_BYTES) = 7.
- WINDOW_BYTES, 16, bytes presented to the decoder per cycle; power of two, at most 32.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- fetch_offset_in  in  OW  fetch write pointer; bytes written so far, modulo BUF_BYTES.
- decode_buffer_in  in  BUF_BYTES*8  buffer contents; byte i is at bits [i*8 +: 8], big-endian bit order [0:N-1].
- flush_in  in  1  resteer flush; asserted the same cycle fetch accepts a resteer.
- decode_offset_in  out  OW  read pointer, fed back to fetch.
- win_valid  out  1  window holds at least one valid byte.
- win_bytes  out  WINDOW_BYTES*8  window; byte 0 is the byte at decode_offset_in, at bits [0 +: 8].
- win_avail  out  log2(WINDOW_BYTES)+1  valid bytes in the window, 0..WINDOW_BYTES.
- consume_valid  in  1  decoder retires one instruction this cycle.
- consume_len  in  log2(WINDOW_BYTES)+1  length of the retired instruction in bytes.
- err_consume  out  1  sticky flag: an illegal consume was attempted.
- stall_cycles  out  32  statistics counter (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - decode_offset_in=0, win_valid=0, win_bytes=0, win_avail=0, err_consume=0, stall_cycles=0.
- Availability:
  - avail = (fetch_offset_in - decode_offset_in) mod BUF_BYTES, computed at OW bits.
  - avail=0 means empty; fetch guarantees the full case is never reached.
- Consume acceptance:
  - A consume is legal iff consume_valid=1, win_valid=1 and 1 <= consume_len <= win_avail.
- Next read pointer:
  - next_off = decode_offset_in + consume_len (mod BUF_BYTES) if the consume is legal; otherwise decode_offset_in.
- Illegal consume:
  - consume_valid=1 with win_valid=0, consume_len=0, or consume_len>win_avail.
  - The pointer does not move; err_consume is set and held until reset.
- Window register, updated every cycle:
  - win_bytes[k] = decode_buffer_in byte (next_off+k) mod BUF_BYTES, for k < min(next_avail, WINDOW_BYTES); remaining bytes are forced to 0.
  - next_avail = (fetch_offset_in - next_off) mod BUF_BYTES.
  - win_avail = min(next_avail, WINDOW_BYTES); win_valid = (win_avail != 0).
- Latency:
  - Window reflects a fetch_offset_in change one cycle later.
  - After a legal consume, the next cycle's window already starts at the new offset, so back-to-back consumes are possible every cycle.
- Data stability:
  - Bytes in [decode_offset, fetch_offset) are never rewritten by fetch, so registering them is safe.
- Wrap-around:
  - Window byte indices wrap modulo BUF_BYTES; a window spanning bytes 120..127 and 0..7 is contiguous at the output.
- Flush (synchronous; flush_in=1):
  - decode_offset_in<=0, win_valid<=0, win_avail<=0, win_bytes<=0; a simultaneous consume is ignored.
  - err_consume is not affected.
- Simultaneous flush and reset: reset wins.
- Reset mid-operation: all state returns to reset values immediately, with no partial window.

Optional Feature:
- Macro: DECODE_WINDOW_STATS_EN.
- Defined:
  - stall_cycles increments by 1 each cycle where consume_valid=0 and win_avail < WINDOW_BYTES and flush_in=0.
  - Saturates at 32'hFFFFFFFF; cleared only by reset.
- Not defined:
  - stall_cycles is tied to 0 and no counter logic is synthesized; port list is unchanged.

Test Plan:
- Reset, then fetch_offset_in=8 with buffer bytes 0..7 = 0x10..0x17 -> next cycle win_valid=1, win_avail=8, win_bytes bytes 0..7 = 0x10..0x17 and bytes 8..15 = 0; decode_offset_in=0.
- fetch_offset_in=24, consume_len=3 accepted -> decode_offset_in=3; next cycle win_avail=16, win byte 0 = buffer byte 3; then consume_len=5 two cycles in a row -> decode_offset_in=8 then 13.
- decode_offset=120, fetch_offset_in=8 -> win_avail=16, window = buffer bytes 120..127 then 0..7; consume 10 -> decode_offset_in=2.
- win_avail=4, consume_len=6 -> decode_offset_in unchanged, err_consume=1 and stays 1; consume with consume_len=0 -> no pointer move.
- decode_offset=40 with flush_in=1 and consume_valid=1 -> next cycle decode_offset_in=0, win_valid=0; fetch_offset_in later 8 -> window shows bytes 0..7.
- With DECODE_WINDOW_STATS_EN defined: hold win_avail=4 with no consume for 10 cycles -> stall_cycles=10. Without the macro -> stall_cycles=0.
